// File: rtl/key_counter.sv
// key_counter: 4-bit up/down/load counter driven by three active-low pushbuttons.
// Each key is synchronized and debounced on its own; a press is a debounced 1->0 transition.
module key_counter #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [2:0] KEY,
  input  logic [3:0] SW,
  output logic [3:0] COUNT,
  output logic       WRAP
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [2:0]    sync1_r;
  logic [2:0]    sync2_r;
  logic [2:0]    db_r;
  logic [2:0]    db_d_r;
  logic [CW-1:0] cnt_r [3];
  logic [2:0]    press_s;
  logic [3:0]    count_r;
  logic [3:0]    count_nxt_s;
  logic          wrap_r;
  logic          wrap_nxt_s;

  assign press_s = db_d_r & ~db_r;

  // Synchronize, debounce and delay each key; db only moves after a full stable run.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_r <= 3'b111;
      sync2_r <= 3'b111;
      db_r    <= 3'b111;
      db_d_r  <= 3'b111;
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      sync1_r <= KEY;
      sync2_r <= sync1_r;
      db_d_r  <= db_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == db_r[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == CNT_LAST) begin
          db_r[i]  <= sync2_r[i];
          cnt_r[i] <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Event priority: load, then simultaneous up+down cancels, then up, then down.
  always_comb begin
    count_nxt_s = count_r;
    wrap_nxt_s  = 1'b0;
    if (press_s[2]) begin
      count_nxt_s = SW;
    end else if (press_s[0] && press_s[1]) begin
      count_nxt_s = count_r;
    end else if (press_s[0]) begin
      count_nxt_s = count_r + 4'd1;
      wrap_nxt_s  = (count_r == 4'd15);
    end else if (press_s[1]) begin
      count_nxt_s = count_r - 4'd1;
      wrap_nxt_s  = (count_r == 4'd0);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count_r <= 4'd0;
      wrap_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      wrap_r  <= wrap_nxt_s;
    end
  end

  assign COUNT = count_r;
  assign WRAP  = wrap_r;

endmodule

// File: tb/tb_key_counter.sv
// tb_key_counter: directed stimulus with a sliding-window debounce model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_key_counter;

  localparam int D = 4;

  logic       clock_50;
  logic       reset;
  logic [2:0] key;
  logic [3:0] sw;
  logic [3:0] count;
  logic       wrap;

  int n_checks = 0;
  int n_pass   = 0;
  int wrap_cnt = 0;

  key_counter #(.DEBOUNCE_CYCLES(D)) dut (
    .CLOCK_50(clock_50),
    .reset   (reset),
    .KEY     (key),
    .SW      (sw),
    .COUNT   (count),
    .WRAP    (wrap)
  );

  initial clock_50 = 1'b0;
  always #5 clock_50 = ~clock_50;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Model: a key's accepted level flips once the D samples taken two or more edges ago
  // all disagree with it; a press is an accepted high->low change, acted on one edge later.
  initial begin : model_and_compare
    logic [D:0] hist [3];
    logic [2:0] acc;
    logic [2:0] acc_prev;
    logic [2:0] ev;
    logic [3:0] exp_count;
    logic       exp_wrap;
    for (int i = 0; i < 3; i++) hist[i] = '1;
    acc = 3'b111; acc_prev = 3'b111; exp_count = 4'd0; exp_wrap = 1'b0;
    forever begin
      @(posedge clock_50);
      #2;
      if (reset) begin
        for (int i = 0; i < 3; i++) hist[i] = '1;
        acc = 3'b111; acc_prev = 3'b111; exp_count = 4'd0; exp_wrap = 1'b0;
      end else begin
        ev = acc_prev & ~acc;
        exp_wrap = 1'b0;
        if (ev[2]) exp_count = sw;
        else if (ev[0] && ev[1]) exp_count = exp_count;
        else if (ev[0]) begin
          exp_wrap = (exp_count == 4'd15);
          exp_count = exp_count + 4'd1;
        end else if (ev[1]) begin
          exp_wrap = (exp_count == 4'd0);
          exp_count = exp_count - 4'd1;
        end
        acc_prev = acc;
        for (int i = 0; i < 3; i++) begin
          if (hist[i][D:1] == {D{~acc[i]}}) acc[i] = ~acc[i];
          hist[i] = {hist[i][D-1:0], key[i]};
        end
      end
      if (wrap === 1'b1) wrap_cnt++;
      chk("model_count", count, exp_count);
      chk("model_wrap", {3'b000, wrap}, {3'b000, exp_wrap});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock_50);
  endtask

  // Hold the keys in mask low for low_cycles edges, then release and idle.
  task automatic press(input logic [2:0] mask, input int low_cycles, input int idle);
    key = 3'b111 & ~mask;
    cyc(low_cycles);
    key = 3'b111;
    cyc(idle);
  endtask

  initial begin : stimulus
    reset = 1'b1;
    key   = 3'b111;
    sw    = 4'h0;
    cyc(3);
    chk("reset_count", count, 4'd0);
    chk("reset_wrap", {3'b000, wrap}, 4'd0);
    reset = 1'b0;
    cyc(2);

    // Held up key: count moves at edge D+2 and only once.
    key = 3'b110;
    cyc(6);
    chk("up_before_edge6", count, 4'd0);
    cyc(1);
    chk("up_at_edge6", count, 4'd1);
    cyc(15);
    chk("up_held_no_repeat", count, 4'd1);
    key = 3'b111;
    cyc(10);

    // Glitch one sample short of acceptance, then exactly long enough.
    press(3'b001, D - 1, 12);
    chk("glitch_rejected", count, 4'd1);
    press(3'b001, D, 12);
    chk("min_press_accepted", count, 4'd2);

    // Load 15 then wrap both ways.
    sw = 4'hF;
    press(3'b100, 8, 10);
    chk("load_15", count, 4'd15);
    chk("load_no_wrap", wrap_cnt[3:0], 4'd0);
    press(3'b001, 8, 10);
    chk("up_wrap_to_0", count, 4'd0);
    chk("up_wrap_pulses", wrap_cnt[3:0], 4'd1);
    press(3'b010, 8, 10);
    chk("down_wrap_to_15", count, 4'd15);
    chk("down_wrap_pulses", wrap_cnt[3:0], 4'd2);

    // Simultaneous events.
    sw = 4'h7;
    press(3'b100, 8, 10);
    chk("load_7", count, 4'd7);
    press(3'b011, 8, 10);
    chk("up_down_cancel", count, 4'd7);
    sw = 4'h3;
    press(3'b101, 8, 10);
    chk("load_beats_up", count, 4'd3);
    sw = 4'hA;
    cyc(10);
    chk("sw_without_load", count, 4'd3);

    // Reset mid-debounce with the up key still held.
    sw = 4'h9;
    press(3'b100, 8, 10);
    chk("load_9", count, 4'd9);
    key = 3'b110;
    cyc(3);
    reset = 1'b1;
    cyc(1);
    chk("reset_mid_debounce", count, 4'd0);
    reset = 1'b0;
    cyc(6);
    chk("post_reset_before_edge6", count, 4'd0);
    cyc(1);
    chk("post_reset_edge6", count, 4'd1);
    chk("post_reset_wrap", {3'b000, wrap}, 4'd0);
    key = 3'b111;
    cyc(12);
    chk("final_count", count, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_counter.md
KEY_COUNTER -- requirements
Module: key_counter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles (≥2) to accept a key change (10 ms at 50 MHz).
REQ-002 SHALL have port CLOCK_50  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port KEY  input  3  raw active-low asynchronous pushbuttons: KEY[0]=up, KEY[1]=down, KEY[2]=load.
REQ-005 SHALL have port SW  input  4  load value, sampled on an accepted load press.
REQ-006 SHALL have port COUNT  output  4  registered unsigned count 0-15, driving the downstream 7-segment decoder SW input.
REQ-007 SHALL have port WRAP  output  1  registered one-cycle pulse on wrap-around.

Function
REQ-008 Each KEY bit SHALL pass through a two-flop synchronizer before any other use.
REQ-009 Per key: debounced state db, stability counter cnt; synchronized value equal to db -> cnt cleared; unequal -> cnt increments; db SHALL take the synchronized value, cnt cleared, at the edge where cnt = DEBOUNCE_CYCLES-1 and mismatch persists.
REQ-010 Any mismatch interrupted before acceptance SHALL clear cnt, leaving db unchanged (glitch rejection).
REQ-011 A press event SHALL be a single-cycle db transition 1->0 (db registered once more to detect it); release (0->1) SHALL generate no event.
REQ-012 With edge 0 = first edge sampling a KEY bit low, held stable, COUNT SHALL update at edge DEBOUNCE_CYCLES+2.
REQ-013 Priority per cycle: load event -> COUNT <= SW; else up and down both -> COUNT unchanged, WRAP 0; else up -> COUNT+1; else down -> COUNT-1.
REQ-014 Arithmetic SHALL be 4-bit modulo 16: up from 15 -> 0, down from 0 -> 15.
REQ-015 WRAP SHALL be 1 for exactly the cycle COUNT holds the wrapped value (after 15->0 or 0->15), else 0; load never asserts WRAP.
REQ-016 A key held indefinitely SHALL yield exactly one event (no auto-repeat); a new event requires accepted release then accepted press.
REQ-017 Keys SHALL debounce independently; events from different keys in the same cycle resolve per REQ-013.
REQ-018 SW changes without a load event SHALL not affect COUNT.

Reset
REQ-019 While reset=1 at a rising edge: synchronizer flops and db/db-delayed <= 1 (released), all cnt <= 0, COUNT <= 0, WRAP <= 0.
REQ-020 Reset SHALL override any in-progress debounce or event in that cycle.
REQ-021 A key held low across reset deassertion SHALL be accepted as a new press per REQ-012 timing counted from the first post-reset edge.

Verification (DEBOUNCE_CYCLES=4)
REQ-022 Reset, KEY=3'b111 -> COUNT=0, WRAP=0; hold KEY[0]=0 from edge 0 -> COUNT=1 at edge 6, stays 1 while held.
REQ-023 KEY[0] low 3 cycles then high (glitch) -> COUNT unchanged, WRAP=0.
REQ-024 SW=4'hF, press KEY[2] -> COUNT=15, WRAP=0; press KEY[0] -> COUNT=0, WRAP=1 one cycle; press KEY[1] -> COUNT=15, WRAP=1 one cycle.
REQ-025 KEY[0] and KEY[1] pressed same edge from COUNT=7 -> COUNT stays 7; KEY[2] and KEY[0] same edge with SW=4'h3 -> COUNT=3.
REQ-026 COUNT=9, reset pulsed mid-debounce of KEY[0] -> COUNT=0 next edge; KEY[0] still held -> COUNT=1 at post-reset edge 6.
